// File: rtl/wb_defs_pkg.sv
// Shared definitions for the Wishbone read initiator: FSM state encoding and
// fixed bus constants.
package wb_defs;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_HOLD  = ST_HOLD,
        S_DONE  = ST_DONE
    } state_e;

    localparam logic [3:0] WB_SEL_ALL   = 4'hF;
    localparam int         WB_WORD_STEP = 4;

endpackage

// File: rtl/wb_rd_master_outreg.sv
// One-entry valid/ready output register holding {last, data}; reports full and
// drain so the read FSM can avoid issuing into an occupied slot.
module wb_rd_outreg
    import wb_defs::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          last_i,
    input  logic [DW-1:0] dat_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] dat_o,
    output logic          last_o,
    output logic          full_o,
    output logic          drain_o
);

    logic          valid_q, valid_d;
    logic          last_q,  last_d;
    logic [DW-1:0] dat_q,   dat_d;

    always_comb begin
        valid_d = valid_q & ~ready_i;
        last_d  = last_q;
        dat_d   = dat_q;
        // A load may coincide with a drain of the previous word.
        if (load_i) begin
            valid_d = 1'b1;
            last_d  = last_i;
            dat_d   = dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            dat_q   <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            dat_q   <= dat_d;
        end
    end

    assign valid_o = valid_q;
    assign dat_o   = dat_q;
    assign last_o  = last_q;
    assign full_o  = valid_q;
    assign drain_o = valid_q & ready_i;

endmodule

// File: rtl/wb_rd_master.sv
// Wishbone read initiator: one outstanding single-strobe word read at a time,
// words streamed out on valid/ready. Optional WAIT timeout via WB_RD_TIMEOUT_EN.
module wb_rd_master
    import wb_defs::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LENW      = 11,
    parameter int TO_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [LENW-1:0] cmd_len_i,
    output logic [AW-1:0]   wb_adr_o,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [3:0]      wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,
    output logic [DW-1:0]   rd_dat_o,
    output logic            rd_last_o,
    output logic            done_o,
    output logic            err_o
);

    state_e          state_q, state_d;
    logic [AW-1:0]   adr_q,   adr_d;
    logic [LENW-1:0] rem_q,   rem_d;
    logic            abort_q, abort_d;

    logic            out_load;
    logic            out_last;
    logic            out_full;
    logic            out_drain;
    logic [1:0]      adr_lsb_unused;

    assign adr_lsb_unused = cmd_adr_i[1:0];

`ifdef WB_RD_TIMEOUT_EN
    localparam int TOW = $clog2(TO_CYCLES + 1);
    logic [TOW-1:0] to_q, to_d;
`endif

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        rem_d       = rem_q;
        abort_d     = abort_q;
        out_load    = 1'b0;
        out_last    = 1'b0;
        cmd_ready_o = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
`ifdef WB_RD_TIMEOUT_EN
        to_d        = to_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    adr_d   = {cmd_adr_i[AW-1:2], 2'b00};
                    rem_d   = cmd_len_i;
                    abort_d = 1'b0;
                    state_d = (cmd_len_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Strobe only once the output slot is guaranteed free by the ack.
                if (!out_full || out_drain) begin
                    wb_cyc_o = 1'b1;
                    wb_stb_o = 1'b1;
                    state_d  = S_WAIT;
`ifdef WB_RD_TIMEOUT_EN
                    to_d     = '0;
`endif
                end
            end
            S_WAIT: begin
                wb_cyc_o = 1'b1;
                if (wb_err_i) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else if (wb_ack_i) begin
                    out_load = 1'b1;
                    out_last = (rem_q == LENW'(1));
                    rem_d    = rem_q - LENW'(1);
                    adr_d    = adr_q + AW'(WB_WORD_STEP);
                    if (rem_q == LENW'(1))
                        state_d = S_HOLD;
                    else if (!out_full || out_drain)
                        state_d = S_ISSUE;
                    else
                        state_d = S_HOLD;
                end
`ifdef WB_RD_TIMEOUT_EN
                else if (to_q == TOW'(TO_CYCLES - 1)) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_d = to_q + TOW'(1);
                end
`endif
            end
            S_HOLD: begin
                if (out_drain)
                    state_d = (rem_q != '0) ? S_ISSUE : S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                err_o   = abort_q;
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            rem_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            abort_q <= abort_d;
        end
    end

`ifdef WB_RD_TIMEOUT_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            to_q <= '0;
        else
            to_q <= to_d;
    end
`endif

    wb_rd_outreg #(
        .DW (DW)
    ) u_outreg (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .load_i  (out_load),
        .last_i  (out_last),
        .dat_i   (wb_dat_i),
        .ready_i (rd_ready_i),
        .valid_o (rd_valid_o),
        .dat_o   (rd_dat_o),
        .last_o  (rd_last_o),
        .full_o  (out_full),
        .drain_o (out_drain)
    );

    assign wb_adr_o = adr_q;
    assign wb_sel_o = WB_SEL_ALL;
    assign wb_we_o  = 1'b0;

endmodule

// File: doc/wb_rd_master.md
Name: wb_rd_master

Overview:
- Wishbone read initiator: the requesting end for the boot ROM and other read-only Wishbone responders.
- Accepts a command (start byte address, word count) and issues word reads one at a time.
- Returns each read word on a valid/ready stream with a last flag, then signals completion or error.
- Sits between the boot/fetch logic and the Wishbone interconnect; used as the boot copier front-end.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- LENW, 11, width of the word-count field.
- TO_CYCLES, 255, timeout limit in cycles; used only with WB_RD_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high when idle; command accepted on valid&ready.
- cmd_adr_i  in  AW  start byte address; bits [1:0] ignored.
- cmd_len_i  in  LENW  number of words; 0 = no-op.
- wb_adr_o  out  AW  word-aligned read address.
- wb_dat_i  in  DW  read data.
- wb_sel_o  out  4  constant 4'hF.
- wb_we_o  out  1  constant 0.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error.
- rd_valid_o  out  1  read data valid.
- rd_ready_i  in  1  consumer ready.
- rd_dat_o  out  DW  read word.
- rd_last_o  out  1  final word of command.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse, coincident with done_o on abort.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0 except cmd_ready_o = 1 and wb_sel_o = 4'hF; counters cleared.
- States: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE: cmd_ready_o = 1. On accept, latch {adr[AW-1:2],2'b00} and remaining = len.
  - len == 0 → DONE.
  - otherwise → ISSUE.
- ISSUE: cyc = 1, stb = 1 for exactly one cycle → WAIT. At most one read outstanding; the single-cycle strobe is required because the responder's ack is registered off stb.
- WAIT: cyc = 1, stb = 0; hold until ack or err.
  - err (priority over a same-cycle ack): drop cyc, discard data, set abort flag → DONE.
  - ack: capture wb_dat_i into the output register; rd_valid_o = 1; rd_last_o = (remaining == 1); remaining -= 1; adr += 4 (wraps modulo 2^AW); drop cyc.
    - If remaining was 1 → HOLD, waiting for the final drain.
    - Else → ISSUE, provided the output register drains this cycle (rd_ready_i) or is empty; otherwise → HOLD.
- HOLD: cyc = stb = 0.
  - When rd_valid_o & rd_ready_i: → ISSUE if words remain, else → DONE.
- Output register: data and last are stable while rd_valid_o & !rd_ready_i. No new ISSUE while it is full and not draining.
- DONE: done_o = 1 for one cycle; err_o = abort flag; clear the flag → IDLE.
- Timing, with a 1-cycle-ack responder and rd_ready_i = 1: 2 cycles per word.
  - First stb is the cycle after command accept.
  - done_o is the cycle after the last beat handshake.
- Reset mid-operation: cyc, stb and rd_valid_o drop immediately; any partially transferred data is lost; no done_o.
- Unsolicited ack/err outside WAIT: ignored.

Optional Feature:
- Macro: WB_RD_TIMEOUT_EN.
- With it: a counter runs in WAIT. If ack/err is absent for TO_CYCLES cycles, cyc drops and the command aborts exactly as on err (done_o + err_o). The counter clears on entry to WAIT.
- Without it: WAIT holds indefinitely; the counter logic is absent.

Decomposition:
- Shared definitions package (wb_defs):
  - state encoding localparams;
  - WB_SEL_ALL = 4'hF;
  - WB_WORD_STEP = 4.
- One natural sub-module: wb_rd_outreg. It is a 1-entry valid/ready register holding {last, data} and exposes full/drain to the FSM.

Test Plan:
- cmd adr=0x100, len=4, rd_ready=1, ROM model acks 1 cycle after stb → stb pulses at 0x100/0x104/0x108/0x10C on every other cycle; 4 words in order; rd_last only on the 4th; done_o=1, err_o=0 one cycle after the last beat.
- len=3, rd_ready held low 5 cycles after the first rd_valid → no stb during the stall; rd_dat_o stable; remaining words follow once ready rises.
- len=0 → cyc never asserts; done_o pulses the cycle after accept; err_o=0; no rd_valid.
- len=4, responder asserts err on the 2nd read (ack also high) → one word delivered; cyc drops; done_o & err_o pulse together; cmd_ready_o returns to 1.
- WB_RD_TIMEOUT_EN, TO_CYCLES=8, responder never acks → cyc high for 1+8 cycles, then done_o & err_o.
- Reset asserted while in WAIT → cyc/stb/rd_valid drop the same cycle; after release cmd_ready_o=1 and a new len=1 command completes normally.
